// File: rtl/map_port_arbiter_if.sv
// Request/return bundle between the map movers and the arbiter, plus the BRAM
// port B command and read-data signals the arbiter drives and consumes.
interface map_port_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4
);
  logic                      hold;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_din;
  logic [DATA_W-1:0]         mem_dout;

  // The master side is everything around the arbiter: the movers and the BRAM.
  modport master (
    output hold, req, req_we, req_addr, req_wdata, mem_dout,
    input  gnt, rd_valid, rd_data, mem_addr, mem_we, mem_din
  );

  modport slave (
    input  hold, req, req_we, req_addr, req_wdata, mem_dout,
    output gnt, rd_valid, rd_data, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing map BRAM port B between the movers; one access
// per cycle, grant registered with the BRAM command, read data two cycles later.
module map_port_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4
) (
  input  logic              vga_pix_clk,
  input  logic              rst,
  map_port_arbiter_if.slave bus
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_q,      ptr_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q,   mem_we_d;
  logic [DATA_W-1:0]  mem_din_q,  mem_din_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;

  // A requester shown a grant this cycle is still holding req; mask it out.
  assign eligible = bus.req & ~gnt_q & {NUM_REQ{~bus.hold}};

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    ptr_d      = ptr_q;
    // The return tag: a read on the port this cycle returns next cycle.
    rd_valid_d = mem_we_q ? '0 : gnt_q;
    if (found) begin
      gnt_d[win_idx] = 1'b1;
      mem_we_d       = bus.req_we[win_idx];
      mem_addr_d     = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      mem_din_d      = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
      ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      // NOTE: reset also clears the return tag, so a read granted just before rst never returns.
      ptr_q      <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = (|rd_valid_q) ? bus.mem_dout : '0;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_din  = mem_din_q;

  a_gnt_onehot: assert property (@(posedge vga_pix_clk) disable iff (rst) $onehot0(gnt_q));
  a_rd_onehot:  assert property (@(posedge vga_pix_clk) disable iff (rst) $onehot0(rd_valid_q));
  a_no_b2b:     assert property (@(posedge vga_pix_clk) disable iff (rst) (gnt_q & gnt_d) == '0);

endmodule

// File: tb/tb_map_port_arbiter.sv
// Randomised and directed bench for map_port_arbiter: a cycle-level reference
// model predicts grants and read returns into queues that a monitor drains.
module tb_map_port_arbiter;
  localparam int NUM_REQ   = 6;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 4;
  localparam int MAP_DEPTH = 1152;

  logic vga_pix_clk = 1'b0;
  logic rst = 1'b1;
  always #5 vga_pix_clk = ~vga_pix_clk;

  map_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  map_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .vga_pix_clk(vga_pix_clk),
    .rst        (rst),
    .bus        (bus)
  );

  function automatic logic [3:0] init_val(input int a);
    if (a == 37) return 4'h1;
    return 4'((a * 7 + 3) % 16);
  endfunction

  // Port B of the map BRAM: 1-cycle latency, read-first.
  logic [DATA_W-1:0] bram [0:2047];
  bit bram_loaded = 1'b0;
  always @(posedge vga_pix_clk) begin
    if (!bram_loaded) begin
      for (int a = 0; a < 2048; a++) bram[a] <= init_val(a);
      bram_loaded  <= 1'b1;
      bus.mem_dout <= '0;
    end else begin
      bus.mem_dout <= bram[bus.mem_addr];
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
    end
  end

  int cyc = 0;
  logic rst_smp = 1'b1;
  always @(posedge vga_pix_clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; int idx; bit we; int addr; int din; } gnt_exp_t;
  typedef struct { int cyc; int idx; int data; } rd_exp_t;
  gnt_exp_t gq[$];
  rd_exp_t  rq[$];

  // Reference model state
  int ref_mem [0:2047];
  int m_ptr = 0;
  int m_vis = -1;
  int m_vis_prev = -1;

  // Requester state
  bit pend [NUM_REQ];
  bit pwe  [NUM_REQ];
  int paddr[NUM_REQ];
  int pdin [NUM_REQ];
  bit [NUM_REQ-1:0] cont_mask = '0;
  bit rand_mode = 1'b0;
  bit hold_v = 1'b0;
  bit rst_v = 1'b1;

  // Hold-release observation
  int rel_cyc = -1;
  int first_after[NUM_REQ];

  function automatic int rr_pick(input bit [NUM_REQ-1:0] r, input int busy, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (start + k) % NUM_REQ;
      if (r[i] && i != busy) return i;
    end
    return -1;
  endfunction

  function automatic void issue(input int i, input bit we, input int addr, input int din);
    pend[i]  = 1'b1;
    pwe[i]   = we;
    paddr[i] = addr;
    pdin[i]  = din;
  endfunction

  function automatic void new_rand(input int i);
    int addr;
    if ($urandom_range(0, 3) == 0) addr = 100 + int'($urandom_range(0, 1));
    else addr = int'($urandom_range(0, MAP_DEPTH - 1));
    issue(i, $urandom_range(0, 2) == 0, addr, int'($urandom_range(0, 15)));
  endfunction

  task automatic drive();
    logic [NUM_REQ-1:0]        r, w;
    logic [NUM_REQ*ADDR_W-1:0] a;
    logic [NUM_REQ*DATA_W-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) begin
      r[i] = pend[i];
      w[i] = pwe[i];
      a[i*ADDR_W +: ADDR_W] = ADDR_W'(paddr[i]);
      d[i*DATA_W +: DATA_W] = DATA_W'(pdin[i]);
    end
    rst           = rst_v;
    bus.hold      = hold_v;
    bus.req       = r;
    bus.req_we    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Predict what the arbiter does with this cycle's inputs.
  task automatic decide();
    bit [NUM_REQ-1:0] pv;
    int d;
    gnt_exp_t ge;
    rd_exp_t  re;
    d = -1;
    for (int i = 0; i < NUM_REQ; i++) pv[i] = pend[i];
    if (rst_v) begin
      m_ptr = 0;
      for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].cyc == cyc + 1) rq.delete(k);
    end else if (!hold_v) begin
      d = rr_pick(pv, m_vis, m_ptr);
      if (d >= 0) begin
        ge = '{cyc: cyc + 1, idx: d, we: pwe[d], addr: paddr[d], din: pdin[d]};
        gq.push_back(ge);
        if (pwe[d]) begin
          ref_mem[paddr[d]] = pdin[d];
        end else begin
          re = '{cyc: cyc + 2, idx: d, data: ref_mem[paddr[d]]};
          rq.push_back(re);
        end
        m_ptr = (d + 1) % NUM_REQ;
      end
    end
    m_vis_prev = m_vis;
    m_vis      = d;
  endtask

  task automatic step();
    @(posedge vga_pix_clk);
    #1;
    if (m_vis_prev >= 0) pend[m_vis_prev] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && (cont_mask[i] || (rand_mode && $urandom_range(0, 99) < 40))) new_rand(i);
    end
    drive();
    decide();
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle.
  initial begin
    int exp_last_addr;
    int exp_last_din;
    logic [NUM_REQ-1:0] prev_gnt;
    gnt_exp_t e;
    rd_exp_t  r;
    exp_last_addr = 0;
    exp_last_din  = 0;
    prev_gnt      = '0;
    forever begin
      @(negedge vga_pix_clk);
      if (rst_smp) begin
        check("reset_gnt",      bus.gnt,      0);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_mem_we",   bus.mem_we,   0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_mem_din",  bus.mem_din,  0);
        exp_last_addr = 0;
        exp_last_din  = 0;
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) void'(gq.pop_front());
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        e = gq.pop_front();
        check("gnt",      bus.gnt,      64'(1) << e.idx);
        check("mem_we",   bus.mem_we,   64'(e.we));
        check("mem_addr", bus.mem_addr, 64'(e.addr));
        check("mem_din",  bus.mem_din,  64'(e.din));
        exp_last_addr = e.addr;
        exp_last_din  = e.din;
      end else begin
        check("gnt_idle",      bus.gnt,      0);
        check("mem_we_idle",   bus.mem_we,   0);
        check("mem_addr_hold", bus.mem_addr, 64'(exp_last_addr));
        check("mem_din_hold",  bus.mem_din,  64'(exp_last_din));
      end
      check("gnt_twice_in_2", 64'(bus.gnt & prev_gnt), 0);
      prev_gnt = bus.gnt;
      while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check("rd_valid", bus.rd_valid, 64'(1) << r.idx);
        check("rd_data",  bus.rd_data,  64'(r.data));
      end else begin
        check("rd_valid_idle", bus.rd_valid, 0);
      end
      if (rel_cyc >= 0 && cyc > rel_cyc) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.gnt[i] && first_after[i] < 0) first_after[i] = cyc;
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 2048; a++) ref_mem[a] = int'(init_val(a));
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = 0; pdin[i] = 0; first_after[i] = -1;
    end
    drive();
    repeat (3) step();
    rst_v = 1'b0;
    repeat (2) step();

    // Single read of address 37 (holds 4'h1)
    issue(2, 1'b0, 37, 0);
    repeat (5) step();

    // Write 4'h8 to 100, then read it back on the next grant
    issue(1, 1'b1, 100, 8);
    step();
    issue(0, 1'b0, 100, 0);
    repeat (5) step();

    // Wrap-around: grant 4 alone (ptr -> 5), then 0 and 5 together
    issue(4, 1'b0, 200, 0);
    repeat (3) step();
    issue(0, 1'b0, 300, 0);
    issue(5, 1'b1, 301, 5);
    repeat (5) step();

    // All six requesting continuously from reset
    rst_v = 1'b1;
    repeat (2) step();
    rst_v = 1'b0;
    cont_mask = '1;
    repeat (24) step();
    cont_mask = '0;
    repeat (8) step();

    // Hold for 10 cycles with everyone requesting, then release
    cont_mask = '1;
    hold_v = 1'b1;
    repeat (10) step();
    hold_v = 1'b0;
    step();
    rel_cyc = cyc;
    repeat (9) step();
    for (int i = 0; i < NUM_REQ; i++) begin
      check($sformatf("hold_release_gnt%0d", i),
            64'(first_after[i] > rel_cyc && first_after[i] <= rel_cyc + NUM_REQ), 1);
    end
    rel_cyc = -1;
    cont_mask = '0;
    repeat (8) step();

    // Reset while a read grant to requester 3 is on the port
    issue(3, 1'b0, 500, 0);
    step();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    step();
    cont_mask = '1;
    repeat (8) step();
    cont_mask = '0;
    repeat (8) step();

    // Requester 4 never drops req, requester 1 also active
    cont_mask = 6'b010010;
    repeat (14) step();
    cont_mask = '0;
    repeat (6) step();

    // Random traffic with occasional hold
    rand_mode = 1'b1;
    repeat (400) begin
      hold_v = ($urandom_range(0, 9) == 0);
      step();
    end
    rand_mode = 1'b0;
    hold_v = 1'b0;
    repeat (12) step();

    check("grant_queue_drained", 64'(gq.size()), 0);
    check("read_queue_drained",  64'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
